// File: rtl/dmem_responder.sv
// dmem_responder: single-port 16-bit data memory behind a valid/ready request
// and response handshake, with a fixed, parameterised access latency.
// Optional build macro DMEM_RESP_ALIGN_CHK_EN: an odd byte address faults the
// request (resp_err=1, no array write). Without it, req_addr[0] is ignored and
// resp_err is always 0.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // WAIT lasts LATENCY-1 cycles; the array access happens on the first edge
    // spent in RESP, so resp_valid rises exactly LATENCY edges after acceptance.
    // LATENCY=1 skips WAIT entirely.
    localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    logic [15:0] mem [2**ADDR_W];

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              mis_q, mis_d;
    logic              valid_q, valid_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_we;

    // Address bits above the word index (and bit 0 when unchecked) are don't-care.
    logic unused_addr;
    assign unused_addr = &{1'b0, req_addr};

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Next-state, request capture and response formation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    idx_d   = req_addr[ADDR_W:1];
                    wdata_d = req_wdata;
`ifdef DMEM_RESP_ALIGN_CHK_EN
                    mis_d   = req_addr[0];
`else
                    mis_d   = 1'b0;
`endif
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    if (mis_q) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (wr_q) begin
                        rdata_d = '0;
                        err_d   = 1'b0;
                        mem_we  = 1'b1;
                    end else begin
                        rdata_d = mem[idx_q];
                        err_d   = 1'b0;
                    end
                end else if (resp_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and response registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses LATENCY=4, instance 1 LATENCY=1.
module tb_dmem_responder;

    typedef struct {
        int          id;
        logic [15:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_wr     [2];
    logic [15:0] req_addr   [2];
    logic [15:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [15:0] resp_rdata [2];
    logic        resp_err   [2];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_responder #(
            .ADDR_W (10),
            .LATENCY(g == 0 ? 4 : 1)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_wr    (req_wr[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitors: measure latency, check hold stability, pop scoreboard on handshake.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        int          acc_cyc  = 0;
        int          rise_cyc = 0;
        logic        prev_v   = 1'b0;
        logic [15:0] held_rd;
        logic        held_err;
        exp_t        e;
        always @(negedge clk) begin
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (req_valid[g] && req_ready[g]) acc_cyc = cyc + 1;
                if (resp_valid[g]) begin
                    if (!prev_v) begin
                        rise_cyc = cyc;
                        held_rd  = resp_rdata[g];
                        held_err = resp_err[g];
                    end else begin
                        chk("hold_rdata", 32'(resp_rdata[g]), 32'(held_rd));
                        chk("hold_err", 32'(resp_err[g]), 32'(held_err));
                    end
                    chk("req_ready_busy", 32'(req_ready[g]), 32'd0);
                    if (resp_ready[g]) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_resp", 32'(g), 32'hFFFF_FFFF);
                        end else begin
                            e = sb.pop_front();
                            chk("resp_inst", 32'(g), 32'(e.id));
                            chk("resp_rdata", 32'(resp_rdata[g]), 32'(e.rd));
                            chk("resp_err", 32'(resp_err[g]), 32'(e.err));
                            chk("latency", 32'(rise_cyc - acc_cyc), 32'(e.lat));
                        end
                    end
                end
                prev_v = resp_valid[g];
            end
        end
    end

    // One full transaction; called and returns at #1 after a rising edge.
    task automatic xact(input int d, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd,
                        input logic exp_err, input int hold);
        int n;
        sb.push_back('{d, exp_rd, exp_err, (d == 0) ? 4 : 1});
        req_valid[d]  = 1'b1;
        req_wr[d]     = wr;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        resp_ready[d] = (hold == 0);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (req_ready[d] && n < 20);
        chk("accept_edges", 32'(n), 32'd1);
        req_valid[d] = 1'b0;
        req_wr[d]    = ~wr;
        req_addr[d]  = ~addr;
        req_wdata[d] = 16'hDEAD;
        n = 0;
        while (!resp_valid[d] && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (!resp_valid[d]) chk("resp_timeout", 32'd0, 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_valid", 32'(resp_valid[d]), 32'd0);
        chk("post_hs_ready", 32'(req_ready[d]), 32'd1);
        resp_ready[d] = 1'b0;
    endtask

    task automatic chk_reset_outputs(input int d);
        chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata[d]), 32'd0);
        chk("rst_resp_err", 32'(resp_err[d]), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_wr[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0;   resp_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst_n = 1'b1;

        // LATENCY=4: store/load, stall, aliasing
        xact(0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 0);
        xact(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 0);
        xact(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 5);
        xact(0, 1'b1, 16'h0004, 16'hAAAA, 16'h0000, 1'b0, 0);
        xact(0, 1'b1, 16'h0804, 16'h5555, 16'h0000, 1'b0, 0);
        xact(0, 1'b0, 16'h0004, 16'h0000, 16'h5555, 1'b0, 0);

        // Reset two cycles into a store: abandoned, array untouched
        xact(0, 1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0, 0);
        req_valid[0] = 1'b1; req_wr[0] = 1'b1;
        req_addr[0]  = 16'h0020; req_wdata[0] = 16'h7777;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (req_ready[0] && n < 20);
        chk("abort_accept", 32'(n), 32'd1);
        req_valid[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xact(0, 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 0);

        // Odd byte address
`ifdef DMEM_RESP_ALIGN_CHK_EN
        xact(0, 1'b1, 16'h0011, 16'hCAFE, 16'h0000, 1'b1, 0);
        xact(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 0);
        xact(0, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, 2);
`else
        xact(0, 1'b1, 16'h0011, 16'hCAFE, 16'h0000, 1'b0, 0);
        xact(0, 1'b0, 16'h0010, 16'h0000, 16'hCAFE, 1'b0, 0);
        xact(0, 1'b0, 16'h0011, 16'h0000, 16'hCAFE, 1'b0, 2);
`endif

        // LATENCY=1 instance
        xact(1, 1'b1, 16'h0002, 16'h1234, 16'h0000, 1'b0, 0);
        xact(1, 1'b0, 16'h0002, 16'h0000, 16'h1234, 1'b0, 0);
        xact(1, 1'b0, 16'h0002, 16'h0000, 16'h1234, 1'b0, 2);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
